sum_bcd_converter: RTL and testbench
====================================

Name: sum_bcd_converter

Overview:
Downstream consumer of the registered nibble-adder sum. It accepts one binary sum per valid/ready handshake and converts it to packed BCD digits with an iterative shift-add-3 (double-dabble) sequencer. It presents the result on a valid/ready output for display or readout logic. One conversion is in flight at a time; there is no pipelining.

Parameters:
- IN_W, 5, width of the binary input sum (5 covers the 4b+4b sum range 0..30).
- DIGITS, 2, number of BCD digits produced.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, in_sum is valid this cycle.
- in_ready, output, 1, block can accept a sum; equals (state==IDLE).
- in_sum, input, IN_W, binary sum to convert.
- out_valid, output, 1, out_bcd/out_overflow hold a completed result.
- out_ready, input, 1, consumer accepts the result.
- out_bcd, output, 4*DIGITS, packed BCD; digit 0 is in [3:0].
- out_overflow, output, 1, captured sum was >= 10**DIGITS.
- out_seg, output, 7*DIGITS, only present with SUM_BCD_SEG_EN; see Optional Feature.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - state=IDLE.
  - out_valid=0, out_bcd=0, out_overflow=0.
  - Internal shift register, scratch digits and counter all 0.
  - in_ready=1 while in IDLE, including during reset; inputs are ignored while reset is high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_sum into the shift register, clear the scratch digits, load cnt=IN_W-1, compute the overflow flag (in_sum >= 10**DIGITS), and go to SHIFT.
- SHIFT:
  - in_ready=0.
  - One iteration per edge: every scratch digit >=5 gets +3, then {digits, sreg} shifts left by 1.
  - Bits shifted out past the top digit are discarded, so the result is value mod 10**DIGITS.
  - When cnt==0 the iteration completes: load out_bcd and out_overflow, set out_valid=1, go to DONE. Otherwise cnt decrements.
- Latency: acceptance at edge t gives out_valid=1 after edge t+IN_W (5 cycles by default).
- DONE:
  - out_valid=1 and in_ready=0.
  - out_bcd and out_overflow are stable until the handshake.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - A new sum cannot be accepted in the same cycle as the output handshake. Minimum throughput is one conversion per IN_W+2 cycles.
- out_bcd and out_overflow change only on the SHIFT-to-DONE edge. After the handshake they hold their values until the next conversion completes.
- Backpressure: out_ready=0 holds DONE indefinitely with no data change. in_valid during SHIFT or DONE is ignored and is not queued.
- Reset mid-operation: immediately returns to IDLE with reset values. The partial conversion is lost and no out_valid pulse occurs.
- Widths: internal scratch is 4*DIGITS bits. The +3 correction is per 4-bit digit with no carry between digits.

Optional Feature:
- Macro: SUM_BCD_SEG_EN.
- Defined:
  - Adds port out_seg[7*DIGITS-1:0]: active-high seven-segment code per digit in order {g,f,e,d,c,b,a}. Examples: digit 0 = 7'h3F, 1 = 7'h06, 3 = 7'h4F, 9 = 7'h6F.
  - out_seg is registered together with out_bcd, with identical timing and hold rules. Reset value is 0.
- Not defined: port and logic are absent; all other behaviour is unchanged.

Decomposition:
- Package sum_bcd_pkg contains:
  - state enum {IDLE, SHIFT, DONE};
  - localparam BCD_DIGIT_W=4;
  - the seven-segment digit constant table.
- One sub-module, bcd_to_seg7: purely combinational, one instance per digit, instantiated only under SUM_BCD_SEG_EN.

Test Plan:
- Basic conversion: in_sum=30 with in_valid, out_ready=1 -> out_valid rises 5 cycles after acceptance; out_bcd=8'h30, out_overflow=0; back in IDLE on the next edge.
- Boundary values: in_sum=0 -> 8'h00; in_sum=19 -> 8'h19; in_sum=9 -> 8'h09. Each conversion is launched back-to-back as soon as in_ready returns.
- Backpressure: in_sum=27, out_ready=0 for 10 cycles, in_valid held high with in_sum=5 -> out_bcd stays 8'h27 and in_ready stays 0. After out_ready=1, the next accepted conversion yields 8'h05.
- Reset mid-SHIFT: assert reset 2 cycles after accepting 25 -> out_valid=0, out_bcd=0, state IDLE. Then 25 again -> 8'h25.
- Overflow: DIGITS=1, in_sum=12 -> out_bcd=4'h2, out_overflow=1; in_sum=9 -> 4'h9, out_overflow=0.
- With SUM_BCD_SEG_EN: in_sum=30 -> out_seg={7'h4F,7'h3F}; out_seg=0 after reset.

Source files
------------

// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum-to-BCD converter.
// Optional seven-segment output is enabled by defining SUM_BCD_SEG_EN.
package sum_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;

   // Active-high {g,f,e,d,c,b,a}; non-decimal codes are blank.
   localparam logic [6:0] SEG7_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00
   };

endpackage

// File: rtl/sum_bcd_converter_bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder.
// Only instantiated when SUM_BCD_SEG_EN is defined.
module bcd_to_seg7
   import sum_bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [6:0]             o_seg
);

   assign o_seg = SEG7_LUT[i_digit];

endmodule

// File: rtl/sum_bcd_converter.sv
// Iterative double-dabble converter from a binary sum to packed BCD.
// Define SUM_BCD_SEG_EN to add the registered out_seg port.
module sum_bcd_converter
   import sum_bcd_pkg::*;
#(
   parameter int IN_W   = 5,
   parameter int DIGITS = 2
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [IN_W-1:0]               in_sum,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
   output logic                          out_overflow
`ifdef SUM_BCD_SEG_EN
   ,
   output logic [7*DIGITS-1:0]           out_seg
`endif
);

   localparam int BW    = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IN_W-1:0]  r_sreg;
   logic [BW-1:0]    r_dig;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf_cap;
   logic             r_out_valid;
   logic [BW-1:0]    r_out_bcd;
   logic             r_out_ovf;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_step;
   logic             w_finish;
   logic             w_release;
   logic             w_ovf_in;
   logic [BW-1:0]    w_adj;
   logic [BW+IN_W-1:0] w_shift;
   logic [BW-1:0]    w_dig_nxt;
   logic [IN_W-1:0]  w_sreg_nxt;
   logic             w_unused_carry;

   assign w_ovf_in = (64'(in_sum) >= LIMIT);

   // Per-digit +3 correction; digits never carry into each other.
   always_comb begin
      w_adj = r_dig;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_dig[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
            w_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] =
               r_dig[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
         end
      end
   end

   // The top digit bit falls off the end, giving value mod 10**DIGITS.
   assign w_shift        = {w_adj[BW-2:0], r_sreg, 1'b0};
   assign w_dig_nxt      = w_shift[BW+IN_W-1 -: BW];
   assign w_sreg_nxt     = w_shift[IN_W-1:0];
   assign w_unused_carry = w_adj[BW-1];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      w_release   = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_step = 1'b1;
            if (r_cnt == '0) begin
               w_finish    = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_release   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Conversion datapath and held result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sreg      <= '0;
         r_dig       <= '0;
         r_cnt       <= '0;
         r_ovf_cap   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_bcd   <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sreg    <= in_sum;
            r_dig     <= '0;
            r_cnt     <= CNT_W'(IN_W - 1);
            r_ovf_cap <= w_ovf_in;
         end
         if (w_step) begin
            r_sreg <= w_sreg_nxt;
            r_dig  <= w_dig_nxt;
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
         if (w_finish) begin
            r_out_bcd   <= w_dig_nxt;
            r_out_ovf   <= r_ovf_cap;
            r_out_valid <= 1'b1;
         end
         if (w_release) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign out_valid    = r_out_valid;
   assign out_bcd      = r_out_bcd;
   assign out_overflow = r_out_ovf;

`ifdef SUM_BCD_SEG_EN
   logic [7*DIGITS-1:0] w_seg;
   logic [7*DIGITS-1:0] r_seg;

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_to_seg7 u_seg (
         .i_digit (w_dig_nxt[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_seg   (w_seg[g*7 +: 7])
      );
   end

   // Segment codes load alongside out_bcd and hold with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg <= '0;
      end else if (w_finish) begin
         r_seg <= w_seg;
      end
   end

   assign out_seg = r_seg;
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Directed bench for sum_bcd_converter (DIGITS=2 and DIGITS=1 instances).
// Optional seven-segment checks build when SUM_BCD_SEG_EN is defined.
module tb_sum_bcd_converter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_ready, out_valid, out_ready, out_overflow;
   logic [4:0] in_sum;
   logic [7:0] out_bcd;
   logic       in_valid1, in_ready1, out_valid1, out_ready1, out_overflow1;
   logic [4:0] in_sum1;
   logic [3:0] out_bcd1;
`ifdef SUM_BCD_SEG_EN
   logic [13:0] out_seg;
   logic [6:0]  out_seg1;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sum_bcd_converter #(.IN_W(5), .DIGITS(2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sum       (in_sum),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bcd      (out_bcd),
      .out_overflow (out_overflow)
`ifdef SUM_BCD_SEG_EN
      ,
      .out_seg      (out_seg)
`endif
   );

   sum_bcd_converter #(.IN_W(5), .DIGITS(1)) u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid1),
      .in_ready     (in_ready1),
      .in_sum       (in_sum1),
      .out_valid    (out_valid1),
      .out_ready    (out_ready1),
      .out_bcd      (out_bcd1),
      .out_overflow (out_overflow1)
`ifdef SUM_BCD_SEG_EN
      ,
      .out_seg      (out_seg1)
`endif
   );

   typedef struct {
      logic [4:0] sum;
      logic [7:0] bcd;
      logic       ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one sum on u_dut, return edges from acceptance to out_valid.
   task automatic convert(input logic [4:0] s, output int lat,
                          output logic [7:0] bcd, output logic ovf);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      check("ready_before_launch", 32'(in_ready), 32'd1);
      in_sum   = s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("busy_after_accept", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      bcd = out_bcd;
      ovf = out_overflow;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         seen;
      logic [7:0] bcd;
      logic       ovf;

      vecs[0] = '{5'd30, 8'h30, 1'b0};
      vecs[1] = '{5'd0,  8'h00, 1'b0};
      vecs[2] = '{5'd19, 8'h19, 1'b0};
      vecs[3] = '{5'd9,  8'h09, 1'b0};
      vecs[4] = '{5'd31, 8'h31, 1'b0};
      vecs[5] = '{5'd10, 8'h10, 1'b0};
      vecs[6] = '{5'd7,  8'h07, 1'b0};

      reset      = 1'b1;
      in_valid   = 1'b1;
      in_sum     = 5'd30;
      out_ready  = 1'b1;
      in_valid1  = 1'b0;
      in_sum1    = 5'd0;
      out_ready1 = 1'b1;
      tick();
      tick();
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_bcd", 32'(out_bcd), 32'd0);
      check("reset_out_ovf", 32'(out_overflow), 32'd0);
`ifdef SUM_BCD_SEG_EN
      check("reset_out_seg", 32'(out_seg), 32'd0);
`endif
      in_valid = 1'b0;
      reset    = 1'b0;
      tick();
      check("idle_after_reset", 32'({in_ready, out_valid}), 32'b10);

      for (int i = 0; i < 7; i++) begin
         convert(vecs[i].sum, lat, bcd, ovf);
         check($sformatf("latency[%0d]", i), 32'(lat), 32'd5);
         check($sformatf("bcd[%0d]", i), 32'(bcd), 32'(vecs[i].bcd));
         check($sformatf("ovf[%0d]", i), 32'(ovf), 32'(vecs[i].ovf));
         tick();
         check($sformatf("idle_after_hs[%0d]", i),
               32'({in_ready, out_valid}), 32'b10);
         check($sformatf("hold_after_hs[%0d]", i),
               32'(out_bcd), 32'(vecs[i].bcd));
      end

`ifdef SUM_BCD_SEG_EN
      convert(5'd30, lat, bcd, ovf);
      check("seg_30", 32'(out_seg), 32'({7'h4F, 7'h3F}));
      tick();
`endif

      // Backpressure with in_valid held high across DONE.
      out_ready = 1'b0;
      in_sum    = 5'd27;
      in_valid  = 1'b1;
      tick();
      in_sum = 5'd5;
      seen = 0;
      while (!out_valid && seen < 20) begin
         tick();
         seen++;
      end
      check("bp_latency", 32'(seen), 32'd5);
      check("bp_bcd", 32'(out_bcd), 32'h27);
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("bp_hold[%0d]", c),
               32'({in_ready, out_valid, out_bcd}), 32'({1'b0, 1'b1, 8'h27}));
      end
      out_ready = 1'b1;
      tick();
      check("bp_release", 32'({in_ready, out_valid}), 32'b10);
      tick();
      in_valid = 1'b0;
      check("bp_next_accepted", 32'(in_ready), 32'd0);
      seen = 0;
      while (!out_valid && seen < 20) begin
         tick();
         seen++;
      end
      check("bp_next_latency", 32'(seen), 32'd5);
      check("bp_next_bcd", 32'(out_bcd), 32'h05);
      tick();

      // Reset two cycles into a conversion.
      in_sum   = 5'd25;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("midrst_state",
            32'({in_ready, out_valid, out_overflow, out_bcd}),
            32'({1'b1, 1'b0, 1'b0, 8'h00}));
      tick();
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (out_valid) seen++;
      end
      check("midrst_no_pulse", 32'(seen), 32'd0);
      convert(5'd25, lat, bcd, ovf);
      check("midrst_redo_lat", 32'(lat), 32'd5);
      check("midrst_redo_bcd", 32'(bcd), 32'h25);
      tick();

      // Single-digit instance: wraps mod 10 and flags overflow.
      in_sum1   = 5'd12;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      seen = 0;
      while (!out_valid1 && seen < 20) begin
         tick();
         seen++;
      end
      check("d1_lat_12", 32'(seen), 32'd5);
      check("d1_bcd_12", 32'(out_bcd1), 32'h2);
      check("d1_ovf_12", 32'(out_overflow1), 32'd1);
`ifdef SUM_BCD_SEG_EN
      check("d1_seg_12", 32'(out_seg1), 32'h5B);
`endif
      tick();
      in_sum1   = 5'd9;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      seen = 0;
      while (!out_valid1 && seen < 20) begin
         tick();
         seen++;
      end
      check("d1_bcd_9", 32'(out_bcd1), 32'h9);
      check("d1_ovf_9", 32'(out_overflow1), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
